// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment capture path: glyph patterns {a..g},
// special nibble codes and the sampler state encoding.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h7E;
  localparam logic [6:0] SEG_1     = 7'h30;
  localparam logic [6:0] SEG_2     = 7'h6D;
  localparam logic [6:0] SEG_3     = 7'h79;
  localparam logic [6:0] SEG_4     = 7'h33;
  localparam logic [6:0] SEG_5     = 7'h5B;
  localparam logic [6:0] SEG_6     = 7'h5F;
  localparam logic [6:0] SEG_7     = 7'h70;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h7B;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] BCD_BLANK = 4'hF;
  localparam logic [3:0] BCD_ERR   = 4'hE;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DWELL,
    S_LOCKED
  } sampler_state_t;

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational glyph lookup: segment pattern -> BCD nibble plus an error flag
// for patterns that are neither a digit nor blank.
module seg7_to_bcd
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] bcd,
  output logic       err
);

  always_comb begin
    bcd = BCD_ERR;
    err = 1'b0;
    case (seg)
      SEG_0:     bcd = 4'd0;
      SEG_1:     bcd = 4'd1;
      SEG_2:     bcd = 4'd2;
      SEG_3:     bcd = 4'd3;
      SEG_4:     bcd = 4'd4;
      SEG_5:     bcd = 4'd5;
      SEG_6:     bcd = 4'd6;
      SEG_7:     bcd = 4'd7;
      SEG_8:     bcd = 4'd8;
      SEG_9:     bcd = 4'd9;
      SEG_BLANK: bcd = BCD_BLANK;
      default:   err = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_capture_decoder.sv
// Recovers BCD digits from a multiplexed 7-segment bus: each digit must dwell
// stably before being committed, and complete frames leave on valid/ready.
module seg7_capture_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [NUM_DIGITS-1:0]   frame_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overrun
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

  sampler_state_t          state_q, state_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [IDX_W-1:0]        idx_q, idx_d, sel_idx;
  logic [6:0]              pat_q, pat_d;
  logic                    sample_valid, same_sample, commit;
  logic [3:0]              dec_bcd;
  logic                    dec_err;
  logic [4*NUM_DIGITS-1:0] digit_vec;
  logic [NUM_DIGITS-1:0]   err_vec, captured_q, commit_mask;
  logic                    complete, load, drop;

  seg7_to_bcd u_dec (
    .seg (seg_in),
    .bcd (dec_bcd),
    .err (dec_err)
  );

  assign sample_valid = (dig_sel != '0) &&
                        ((dig_sel & (dig_sel - NUM_DIGITS'(1))) == '0);
  assign same_sample  = (sel_idx == idx_q) && (seg_in == pat_q);

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (dig_sel[i]) sel_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      idx_q   <= '0;
      pat_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      pat_q   <= pat_d;
    end
  end

  // A different valid sample in any state restarts the dwell with count=1;
  // the commit fires on the sample that brings the count to STABLE_CYCLES.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    pat_d   = pat_q;
    commit  = 1'b0;
    if (!sample_valid) begin
      state_d = S_IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        S_DWELL: begin
          if (!same_sample) begin
            count_d = CNT_W'(1);
            idx_d   = sel_idx;
            pat_d   = seg_in;
          end else if (count_q == CNT_W'(STABLE_CYCLES - 1)) begin
            count_d = CNT_W'(STABLE_CYCLES);
            state_d = S_LOCKED;
            commit  = 1'b1;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
        S_LOCKED: begin
          if (!same_sample) begin
            state_d = S_DWELL;
            count_d = CNT_W'(1);
            idx_d   = sel_idx;
            pat_d   = seg_in;
          end
        end
        default: begin
          state_d = S_DWELL;
          count_d = CNT_W'(1);
          idx_d   = sel_idx;
          pat_d   = seg_in;
        end
      endcase
    end
  end

  assign commit_mask = commit ? (NUM_DIGITS'(1) << idx_q) : '0;
  assign complete    = (captured_q == {NUM_DIGITS{1'b1}});
  assign load        = complete && (!out_valid || out_ready);
  assign drop        = complete && out_valid && !out_ready;

  // A completed frame is consumed (loaded or dropped) the cycle after its last commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_vec  <= '0;
      err_vec    <= '0;
      captured_q <= '0;
      bcd_out    <= '0;
      frame_err  <= '0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun    <= drop;
      captured_q <= (complete ? '0 : captured_q) | commit_mask;
      if (commit) begin
        digit_vec[4*idx_q +: 4] <= dec_bcd;
        err_vec[idx_q]          <= dec_err;
      end
      if (load) begin
        bcd_out   <= digit_vec;
        frame_err <= err_vec;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg7_capture_decoder.sv
// Directed and randomized checks of seg7_capture_decoder against a frame-level
// reference model built from the glyph table and dwell rules.
module tb_seg7_capture_decoder;

  localparam int ND     = 4;
  localparam int STABLE = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [6:0]      seg_in;
  logic [ND-1:0]   dig_sel;
  logic [4*ND-1:0] bcd_out;
  logic [ND-1:0]   frame_err;
  logic            out_valid;
  logic            out_ready;
  logic            overrun;

  int compared   = 0;
  int mismatched = 0;

  logic [6:0]      glyph [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                                  7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};
  logic [4*ND-1:0] m_bcd, m_frame_bcd;
  logic [ND-1:0]   m_err, m_frame_err, m_cap;

  seg7_capture_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(STABLE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg_in    (seg_in),
    .dig_sel   (dig_sel),
    .bcd_out   (bcd_out),
    .frame_err (frame_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [4:0] refDecode(input logic [6:0] p);
    for (int i = 0; i < 10; i++) begin
      if (glyph[i] == p) return {1'b0, 4'(i)};
    end
    if (p == 7'h00) return {1'b0, 4'hF};
    return {1'b1, 4'hE};
  endfunction

  function automatic logic [6:0] randPat();
    int unsigned r;
    logic [6:0] p;
    r = $urandom_range(0, 11);
    if (r < 10) return glyph[r];
    if (r == 10) return 7'h00;
    for (int t = 0; t < 20; t++) begin
      p = 7'($urandom);
      if (refDecode(p) == 5'h1E) return p;
    end
    return 7'h01;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [ND-1:0] sel, input logic [6:0] pat, input int n);
    for (int c = 0; c < n; c++) begin
      dig_sel = sel;
      seg_in  = pat;
      tick();
    end
  endtask

  task automatic idle(input int n);
    applyStimulus('0, 7'h00, n);
  endtask

  task automatic modelReset();
    m_bcd = '0;
    m_err = '0;
    m_cap = '0;
  endtask

  // A digit is committed once its sample has been held STABLE cycles in a row.
  task automatic modelCommit(input int idx, input logic [6:0] pat);
    logic [4:0] d;
    d = refDecode(pat);
    m_bcd[4*idx +: 4] = d[3:0];
    m_err[idx]        = d[4];
    m_cap[idx]        = 1'b1;
    if (m_cap == '1) begin
      m_frame_bcd = m_bcd;
      m_frame_err = m_err;
      m_cap       = '0;
    end
  endtask

  task automatic dwell(input int idx, input logic [6:0] pat, input int n);
    applyStimulus(ND'(1 << idx), pat, n);
    if (n >= STABLE) modelCommit(idx, pat);
  endtask

  task automatic accept();
    out_ready = 1'b1;
    tick();
    checkOutput("accept_drops_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; out_ready = 1'b0; dig_sel = '0; seg_in = '0;
    modelReset();
    #12;
    checkOutput("reset_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_bcd", 32'(bcd_out), 32'd0);
    checkOutput("reset_err", 32'(frame_err), 32'd0);
    checkOutput("reset_overrun", 32'(overrun), 32'd0);
    rst_n = 1'b1;
    idle(2);

    $display("[TB] basic frame 4321");
    out_ready = 1'b1;
    dwell(0, 7'h30, 4); dwell(1, 7'h6D, 4); dwell(2, 7'h79, 4); dwell(3, 7'h33, 4);
    checkOutput("basic_valid_at_commit", 32'(out_valid), 32'd0);
    tick();
    checkOutput("basic_valid", 32'(out_valid), 32'd1);
    checkOutput("basic_bcd", 32'(bcd_out), 32'h4321);
    checkOutput("basic_err", 32'(frame_err), 32'd0);
    tick();
    checkOutput("basic_handshake", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    $display("[TB] short dwell leaves no trace");
    dwell(0, 7'h5B, 3); idle(1);
    dwell(1, 7'h70, 4); dwell(2, 7'h7F, 4); dwell(3, 7'h7B, 4); idle(2);
    checkOutput("partial_no_frame", 32'(out_valid), 32'd0);
    dwell(0, 7'h5F, 4); idle(1);
    checkOutput("partial_valid", 32'(out_valid), 32'd1);
    checkOutput("partial_bcd", 32'(bcd_out), 32'h9876);
    accept();

    $display("[TB] glitch restarts dwell");
    dwell(0, 7'h7E, 4); dwell(1, 7'h7E, 4); dwell(3, 7'h7E, 4);
    applyStimulus(4'b0100, 7'h7F, 2);
    applyStimulus(4'b0100, 7'h7E, 1);
    applyStimulus(4'b0100, 7'h7F, 3);
    checkOutput("glitch_no_commit_3", 32'(out_valid), 32'd0);
    applyStimulus(4'b0100, 7'h7F, 1);
    modelCommit(2, 7'h7F);
    checkOutput("glitch_commit_edge", 32'(out_valid), 32'd0);
    tick();
    checkOutput("glitch_valid", 32'(out_valid), 32'd1);
    checkOutput("glitch_bcd", 32'(bcd_out), 32'h0800);
    accept();

    $display("[TB] illegal and blank glyphs");
    dwell(0, 7'h79, 4); dwell(1, 7'h01, 4); dwell(2, 7'h33, 4); dwell(3, 7'h00, 4); idle(1);
    checkOutput("glyph_bcd", 32'(bcd_out), 32'hF4E3);
    checkOutput("glyph_err", 32'(frame_err), 32'b0010);
    accept();

    $display("[TB] overrun and same-cycle reload");
    dwell(0, 7'h5B, 4); dwell(1, 7'h5F, 4); dwell(2, 7'h70, 4); dwell(3, 7'h7F, 4); idle(1);
    checkOutput("ovr_first_bcd", 32'(bcd_out), 32'h8765);
    dwell(0, 7'h7B, 4); dwell(1, 7'h7B, 4); dwell(2, 7'h7B, 4); dwell(3, 7'h7B, 4);
    checkOutput("ovr_not_yet", 32'(overrun), 32'd0);
    tick();
    checkOutput("ovr_pulse", 32'(overrun), 32'd1);
    checkOutput("ovr_held_bcd", 32'(bcd_out), 32'h8765);
    checkOutput("ovr_held_valid", 32'(out_valid), 32'd1);
    tick();
    checkOutput("ovr_one_cycle", 32'(overrun), 32'd0);
    dwell(0, 7'h30, 4); dwell(1, 7'h7E, 4); dwell(2, 7'h30, 4); dwell(3, 7'h7E, 4);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("reload_valid", 32'(out_valid), 32'd1);
    checkOutput("reload_bcd", 32'(bcd_out), 32'h0101);
    checkOutput("reload_no_ovr", 32'(overrun), 32'd0);
    tick();
    checkOutput("reload_held", 32'(out_valid), 32'd1);
    accept();

    $display("[TB] non-one-hot select clears dwell");
    dwell(1, 7'h30, 4); dwell(2, 7'h30, 4); dwell(3, 7'h30, 4);
    applyStimulus(4'b0001, 7'h6D, 2);
    applyStimulus(4'b0011, 7'h6D, 1);
    applyStimulus(4'b0001, 7'h6D, 3);
    idle(1);
    checkOutput("multihot_clears", 32'(out_valid), 32'd0);
    applyStimulus(4'b0001, 7'h6D, 2);
    applyStimulus(4'b0000, 7'h6D, 1);
    applyStimulus(4'b0001, 7'h6D, 3);
    idle(1);
    checkOutput("zerohot_clears", 32'(out_valid), 32'd0);
    dwell(0, 7'h6D, 4); idle(1);
    checkOutput("select_bcd", 32'(bcd_out), 32'h1112);
    accept();

    $display("[TB] reset mid-frame");
    dwell(0, 7'h6D, 4); dwell(1, 7'h6D, 4); dwell(2, 7'h6D, 4); dwell(3, 7'h6D, 4); idle(1);
    checkOutput("prereset_valid", 32'(out_valid), 32'd1);
    dwell(0, 7'h30, 4);
    rst_n = 1'b0;
    #2;
    modelReset();
    checkOutput("async_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("async_rst_bcd", 32'(bcd_out), 32'd0);
    checkOutput("async_rst_err", 32'(frame_err), 32'd0);
    tick();
    rst_n = 1'b1;
    dwell(1, 7'h7E, 4); dwell(2, 7'h7E, 4); dwell(3, 7'h7E, 4); idle(2);
    checkOutput("reset_discards_partial", 32'(out_valid), 32'd0);
    dwell(0, 7'h5B, 4); idle(1);
    checkOutput("postreset_bcd", 32'(bcd_out), 32'h0005);
    accept();

    $display("[TB] randomized frames");
    modelReset();
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < ND; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          dwell(i, randPat(), int'($urandom_range(1, STABLE - 1)));
          idle(1);
        end
        dwell(i, randPat(), int'($urandom_range(STABLE, STABLE + 3)));
      end
      idle(1);
      checkOutput("rand_valid", 32'(out_valid), 32'd1);
      checkOutput("rand_bcd", 32'(bcd_out), 32'(m_frame_bcd));
      checkOutput("rand_err", 32'(frame_err), 32'(m_frame_err));
      accept();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
